// File: rtl/fft_pwr_pkg.sv
// Shared definitions for the FFT power / peak-search block.
//   LOG2_N_DEF, DW_DEF      : default FFT size (log2) and component width
//   DATA_RE_LSB/DATA_IM_LSB : bit positions of re/im inside the 64-bit beat
//   peak_state_e            : peak-search state encoding
package fft_pwr_pkg;

   localparam int LOG2_N_DEF  = 10;
   localparam int DW_DEF      = 27;
   localparam int DATA_RE_LSB = 0;
   localparam int DATA_IM_LSB = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } peak_state_e;

endpackage

// File: rtl/fft_pwr_sq_mac.sv
// Three-stage re^2 + im^2 pipeline with valid/last/index sideband.
//   i_aclk, i_rstn          : clock, async active-low reset
//   i_vld, i_last, i_idx    : input beat qualifier, frame end, bin index
//   i_re, i_im              : signed components
//   o_vld, o_last, o_idx    : sideband delayed by exactly 3 cycles
//   o_pwr                   : unsigned full-precision power
// Stage 1 registers the operands, stage 2 the two squares, stage 3 the sum.
// Valid/last advance every cycle so latency is fixed; data/index only load
// behind a valid beat, so bubbles never disturb held data.
module fft_pwr_sq_mac
   import fft_pwr_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int PW = 2*DW+1,
   parameter int IW = LOG2_N_DEF
) (
   input  logic                 i_aclk,
   input  logic                 i_rstn,
   input  logic                 i_vld,
   input  logic                 i_last,
   input  logic signed [DW-1:0] i_re,
   input  logic signed [DW-1:0] i_im,
   input  logic [IW-1:0]        i_idx,
   output logic                 o_vld,
   output logic                 o_last,
   output logic [PW-1:0]        o_pwr,
   output logic [IW-1:0]        o_idx
);

   localparam int PDW = 2*DW;

   logic                 s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
   logic signed [DW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
   logic [IW-1:0]        s1_idx_q, s1_idx_d;

   logic                 s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
   logic [PDW-1:0]       s2_sq_re_q, s2_sq_re_d, s2_sq_im_q, s2_sq_im_d;
   logic [IW-1:0]        s2_idx_q, s2_idx_d;

   logic                 s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
   logic [PW-1:0]        s3_pwr_q, s3_pwr_d;
   logic [IW-1:0]        s3_idx_q, s3_idx_d;

   always_comb begin
      s1_vld_d   = i_vld;
      s1_last_d  = i_vld & i_last;
      s1_re_d    = s1_re_q;
      s1_im_d    = s1_im_q;
      s1_idx_d   = s1_idx_q;
      if (i_vld) begin
         s1_re_d  = i_re;
         s1_im_d  = i_im;
         s1_idx_d = i_idx;
      end

      s2_vld_d   = s1_vld_q;
      s2_last_d  = s1_last_q;
      s2_sq_re_d = s2_sq_re_q;
      s2_sq_im_d = s2_sq_im_q;
      s2_idx_d   = s2_idx_q;
      if (s1_vld_q) begin
         // Operands widened (sign-extended) first so the square keeps all bits.
         s2_sq_re_d = PDW'(PDW'(s1_re_q) * PDW'(s1_re_q));
         s2_sq_im_d = PDW'(PDW'(s1_im_q) * PDW'(s1_im_q));
         s2_idx_d   = s1_idx_q;
      end

      s3_vld_d   = s2_vld_q;
      s3_last_d  = s2_last_q;
      s3_pwr_d   = s3_pwr_q;
      s3_idx_d   = s3_idx_q;
      if (s2_vld_q) begin
         s3_pwr_d = PW'(s2_sq_re_q) + PW'(s2_sq_im_q);
         s3_idx_d = s2_idx_q;
      end
   end

   always_ff @(posedge i_aclk or negedge i_rstn) begin
      if (!i_rstn) begin
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_re_q    <= '0;
         s1_im_q    <= '0;
         s1_idx_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_sq_re_q <= '0;
         s2_sq_im_q <= '0;
         s2_idx_q   <= '0;
         s3_vld_q   <= 1'b0;
         s3_last_q  <= 1'b0;
         s3_pwr_q   <= '0;
         s3_idx_q   <= '0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_last_q  <= s1_last_d;
         s1_re_q    <= s1_re_d;
         s1_im_q    <= s1_im_d;
         s1_idx_q   <= s1_idx_d;
         s2_vld_q   <= s2_vld_d;
         s2_last_q  <= s2_last_d;
         s2_sq_re_q <= s2_sq_re_d;
         s2_sq_im_q <= s2_sq_im_d;
         s2_idx_q   <= s2_idx_d;
         s3_vld_q   <= s3_vld_d;
         s3_last_q  <= s3_last_d;
         s3_pwr_q   <= s3_pwr_d;
         s3_idx_q   <= s3_idx_d;
      end
   end

   assign o_vld  = s3_vld_q;
   assign o_last = s3_last_q;
   assign o_pwr  = s3_pwr_q;
   assign o_idx  = s3_idx_q;

endmodule

// File: rtl/fft_pwr_peak.sv
// FFT bin power stream plus per-frame peak search.
//   i_aclk, i_rstn            : clock, async active-low reset
//   i_axi4s_data_*            : FFT output beats (no backpressure)
//                               tdata re=[DW-1:0], im=[32+DW-1:32]; tuser bin index
//   o_pwr_*                   : per-bin power, 3 cycles after the input beat
//   o_peak_vld/idx/pwr        : 1-cycle pulse after the frame's last power beat;
//                               idx/pwr hold until the next pulse
// Build option: FFT_PEAK_DC_EXCLUDE_EN removes bin 0 from the peak search.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame open; next valid power beat starts a frame
// ACC     | frame open, running peak being updated
// DONE    | one cycle, o_peak_vld high; a new frame may start here
module fft_pwr_peak
   import fft_pwr_pkg::*;
#(
   parameter int LOG2_N = LOG2_N_DEF,
   parameter int DW     = DW_DEF,
   parameter int PW     = 2*DW+1
) (
   input  logic              i_aclk,
   input  logic              i_rstn,
   input  logic              i_axi4s_data_tvalid,
   input  logic [63:0]       i_axi4s_data_tdata,
   input  logic              i_axi4s_data_tlast,
   input  logic [15:0]       i_axi4s_data_tuser,
   output logic              o_pwr_tvalid,
   output logic [PW-1:0]     o_pwr_tdata,
   output logic              o_pwr_tlast,
   output logic [LOG2_N-1:0] o_pwr_tindex,
   output logic              o_peak_vld,
   output logic [LOG2_N-1:0] o_peak_idx,
   output logic [PW-1:0]     o_peak_pwr
);

   logic signed [DW-1:0] in_re, in_im;
   logic [LOG2_N-1:0]    in_idx;
   logic                 unused_bits;

   assign in_re       = i_axi4s_data_tdata[DATA_RE_LSB +: DW];
   assign in_im       = i_axi4s_data_tdata[DATA_IM_LSB +: DW];
   assign in_idx      = i_axi4s_data_tuser[LOG2_N-1:0];
   assign unused_bits = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

   logic              pwr_vld, pwr_last;
   logic [PW-1:0]     pwr_data;
   logic [LOG2_N-1:0] pwr_idx;

   fft_pwr_sq_mac #(
      .DW (DW),
      .PW (PW),
      .IW (LOG2_N)
   ) u_sq_mac (
      .i_aclk (i_aclk),
      .i_rstn (i_rstn),
      .i_vld  (i_axi4s_data_tvalid),
      .i_last (i_axi4s_data_tlast),
      .i_re   (in_re),
      .i_im   (in_im),
      .i_idx  (in_idx),
      .o_vld  (pwr_vld),
      .o_last (pwr_last),
      .o_pwr  (pwr_data),
      .o_idx  (pwr_idx)
   );

   peak_state_e       state_q, state_d;
   logic [PW-1:0]     run_pwr_q, run_pwr_d, peak_pwr_q, peak_pwr_d;
   logic [LOG2_N-1:0] run_idx_q, run_idx_d, peak_idx_q, peak_idx_d;

   logic              new_frame, bin_eligible;
   logic [PW-1:0]     base_pwr, cand_pwr;
   logic [LOG2_N-1:0] base_idx, cand_idx;

   // Only the lower half of the spectrum is searched (real-input symmetry).
`ifdef FFT_PEAK_DC_EXCLUDE_EN
   assign bin_eligible = !pwr_idx[LOG2_N-1] && (pwr_idx != '0);
`else
   assign bin_eligible = !pwr_idx[LOG2_N-1];
`endif

   always_comb begin
      state_d    = state_q;
      run_pwr_d  = run_pwr_q;
      run_idx_d  = run_idx_q;
      peak_pwr_d = peak_pwr_q;
      peak_idx_d = peak_idx_q;

      // Outside ACC every beat opens a frame; inside ACC an index-0 beat
      // means the previous frame lost its tlast and is abandoned.
      new_frame = (state_q != ST_ACC) || (pwr_idx == '0);
      base_pwr  = new_frame ? '0 : run_pwr_q;
      base_idx  = new_frame ? '0 : run_idx_q;

      // Strict compare: on a tie the earlier (lower) bin is kept.
      if (bin_eligible && (pwr_data > base_pwr)) begin
         cand_pwr = pwr_data;
         cand_idx = pwr_idx;
      end else begin
         cand_pwr = base_pwr;
         cand_idx = base_idx;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (pwr_vld) state_d = pwr_last ? ST_DONE : ST_ACC;
            else         state_d = ST_IDLE;
         end
         ST_ACC: begin
            if (pwr_vld && pwr_last) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (pwr_vld) begin
         run_pwr_d = cand_pwr;
         run_idx_d = cand_idx;
         if (pwr_last) begin
            peak_pwr_d = cand_pwr;
            peak_idx_d = cand_idx;
         end
      end
   end

   always_ff @(posedge i_aclk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= ST_IDLE;
         run_pwr_q  <= '0;
         run_idx_q  <= '0;
         peak_pwr_q <= '0;
         peak_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         run_pwr_q  <= run_pwr_d;
         run_idx_q  <= run_idx_d;
         peak_pwr_q <= peak_pwr_d;
         peak_idx_q <= peak_idx_d;
      end
   end

   assign o_pwr_tvalid = pwr_vld;
   assign o_pwr_tdata  = pwr_data;
   assign o_pwr_tlast  = pwr_last;
   assign o_pwr_tindex = pwr_idx;
   assign o_peak_vld   = (state_q == ST_DONE);
   assign o_peak_idx   = peak_idx_q;
   assign o_peak_pwr   = peak_pwr_q;

endmodule
